// File: rtl/spatz_pkg.sv
// Shared VRF types and write-requester indices for the Spatz vector register file write path.
package spatz_pkg;

  localparam int unsigned VRegAddrWidth = 10;
  localparam int unsigned VRegDataWidth = 32;
  localparam int unsigned VRegBeWidth   = VRegDataWidth / 8;

  typedef logic [VRegAddrWidth-1:0] vreg_addr_t;
  typedef logic [VRegDataWidth-1:0] vreg_data_t;
  typedef logic [VRegBeWidth-1:0]   vreg_be_t;

  // Write requester indices; a lower index has higher base priority.
  localparam int unsigned VFU_VD_WD  = 0;
  localparam int unsigned VLSU_VD_WD = 1;
  localparam int unsigned VSLD_VD_WD = 2;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wr_req_t;

endpackage

// File: rtl/spatz_vrf_wr_bank_slot.sv
// Single-entry output register for one VRF bank write port with a valid/ready handshake.
module spatz_vrf_wr_bank_slot
  import spatz_pkg::*;
#(
  parameter int unsigned SrcW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  vrf_wr_req_t     load_req,
  input  logic [SrcW-1:0] load_src,
  input  logic            bank_ready,
  output logic            free,
  output logic            we,
  output vreg_addr_t      waddr,
  output vreg_data_t      wdata,
  output vreg_be_t        wbe,
  output logic [SrcW-1:0] src
);

  logic            valid_q;
  vrf_wr_req_t     req_q;
  logic [SrcW-1:0] src_q;

  // NOTE: sequential state is written with non-blocking '<=' so every flop samples pre-edge values.
  // NOTE: the payload is reset as well, because the bank-facing outputs must read zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      src_q   <= '0;
    end else begin
      // A load in the same cycle as a drain keeps the slot occupied.
      if (load) begin
        valid_q <= 1'b1;
      end else if (bank_ready) begin
        valid_q <= 1'b0;
      end
      if (load) begin
        req_q <= load_req;
        src_q <= load_src;
      end
    end
  end

  assign free  = !valid_q || bank_ready;
  assign we    = valid_q;
  assign waddr = req_q.addr;
  assign wdata = req_q.data;
  assign wbe   = req_q.be;
  assign src   = src_q;

endmodule

// File: rtl/spatz_vrf_wr_arbiter.sv
// Per-bank write arbiter for the banked VRF: fixed priority with optional starvation boosting
// (enabled by defining SPATZ_VRF_WR_ARB_STARVE_EN) and one registered slot per bank.
module spatz_vrf_wr_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NrReq       = 3,
  parameter int unsigned NrBanks     = 4,
  parameter int unsigned BankLsb     = 0,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic       [NrReq-1:0]                      req_valid_i,
  output logic       [NrReq-1:0]                      req_ready_o,
  input  vreg_addr_t [NrReq-1:0]                      req_addr_i,
  input  vreg_data_t [NrReq-1:0]                      req_data_i,
  input  vreg_be_t   [NrReq-1:0]                      req_be_i,
  output logic       [NrBanks-1:0]                    bank_we_o,
  input  logic       [NrBanks-1:0]                    bank_ready_i,
  output vreg_addr_t [NrBanks-1:0]                    bank_waddr_o,
  output vreg_data_t [NrBanks-1:0]                    bank_wdata_o,
  output vreg_be_t   [NrBanks-1:0]                    bank_wbe_o,
  output logic       [NrBanks-1:0][$clog2(NrReq)-1:0] bank_src_o,
  output logic       [NrReq-1:0]                      starve_o
);

  localparam int unsigned BankW = $clog2(NrBanks);
  localparam int unsigned SrcW  = $clog2(NrReq);

  logic        [NrReq-1:0]              boosted;
  logic        [NrBanks-1:0][NrReq-1:0] cand;
  logic        [NrBanks-1:0]            slot_free;
  logic        [NrBanks-1:0]            load;
  logic        [NrBanks-1:0][SrcW-1:0]  win_idx;
  vrf_wr_req_t [NrBanks-1:0]            load_req;

  // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
  always_comb begin
    cand        = '0;
    load        = '0;
    win_idx     = '0;
    load_req    = '0;
    req_ready_o = '0;
    for (int b = 0; b < int'(NrBanks); b++) begin
      for (int r = 0; r < int'(NrReq); r++) begin
        cand[b][r] = req_valid_i[r] && (req_addr_i[r][BankLsb +: BankW] == BankW'(b));
      end
      // Scan downwards so the lowest index wins; the boosted pass overrides the plain pass.
      for (int r = int'(NrReq) - 1; r >= 0; r--) begin
        if (cand[b][r] && !boosted[r]) win_idx[b] = SrcW'(r);
      end
      for (int r = int'(NrReq) - 1; r >= 0; r--) begin
        if (cand[b][r] && boosted[r]) win_idx[b] = SrcW'(r);
      end
      load[b]     = (|cand[b]) && slot_free[b] && !rst_i;
      load_req[b] = '{addr: req_addr_i[win_idx[b]],
                      data: req_data_i[win_idx[b]],
                      be:   req_be_i[win_idx[b]]};
      if (load[b]) req_ready_o[win_idx[b]] = 1'b1;
    end
  end

`ifdef SPATZ_VRF_WR_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  logic [NrReq-1:0][CntW-1:0] starve_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else begin
      for (int r = 0; r < int'(NrReq); r++) begin
        if (!req_valid_i[r] || req_ready_o[r]) begin
          starve_cnt[r] <= '0;
        end else if (starve_cnt[r] != CntW'(StarveLimit)) begin
          starve_cnt[r] <= starve_cnt[r] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    boosted = '0;
    for (int r = 0; r < int'(NrReq); r++) begin
      boosted[r] = (starve_cnt[r] == CntW'(StarveLimit));
    end
  end
`else
  assign boosted = '0;
`endif

  assign starve_o = boosted;

  for (genvar b = 0; b < int'(NrBanks); b++) begin : g_slot
    spatz_vrf_wr_bank_slot #(
      .SrcW (SrcW)
    ) i_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load       (load[b]),
      .load_req   (load_req[b]),
      .load_src   (win_idx[b]),
      .bank_ready (bank_ready_i[b]),
      .free       (slot_free[b]),
      .we         (bank_we_o[b]),
      .waddr      (bank_waddr_o[b]),
      .wdata      (bank_wdata_o[b]),
      .wbe        (bank_wbe_o[b]),
      .src        (bank_src_o[b])
    );
  end

endmodule

// File: tb/tb_spatz_vrf_wr_arbiter.sv
// Directed and scoreboarded bench for spatz_vrf_wr_arbiter; starvation expectations follow SPATZ_VRF_WR_ARB_STARVE_EN.
module tb_spatz_vrf_wr_arbiter;
  import spatz_pkg::*;

  typedef struct packed {
    vreg_addr_t  addr;
    vreg_data_t  data;
    vreg_be_t    be;
    logic [1:0]  src;
  } exp_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic       [2:0]        req_valid;
  logic       [2:0]        req_ready;
  vreg_addr_t [2:0]        req_addr;
  vreg_data_t [2:0]        req_data;
  vreg_be_t   [2:0]        req_be;
  logic       [3:0]        bank_we;
  logic       [3:0]        bank_ready;
  vreg_addr_t [3:0]        bank_waddr;
  vreg_data_t [3:0]        bank_wdata;
  vreg_be_t   [3:0]        bank_wbe;
  logic       [3:0][1:0]   bank_src;
  logic       [2:0]        starve;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t exp_q[4][$];

  spatz_vrf_wr_arbiter #(
    .NrReq       (3),
    .NrBanks     (4),
    .BankLsb     (0),
    .StarveLimit (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_be_i     (req_be),
    .bank_we_o    (bank_we),
    .bank_ready_i (bank_ready),
    .bank_waddr_o (bank_waddr),
    .bank_wdata_o (bank_wdata),
    .bank_wbe_o   (bank_wbe),
    .bank_src_o   (bank_src),
    .starve_o     (starve)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0; bank_ready = '0;
    #2;
    tests_run++;
    if (req_ready !== 3'b000 || bank_we !== 4'b0000 || starve !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready=%b we=%b starve=%b want 000/0000/000", req_ready, bank_we, starve);
    end
    tests_run++;
    if (bank_wdata !== '0 || bank_waddr !== '0 || bank_wbe !== '0 || bank_src !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: wdata=%h waddr=%h wbe=%h src=%h want all 0", bank_wdata, bank_waddr, bank_wbe, bank_src);
    end
    tick();
    rst_i = 1'b0;
    req_valid = 3'b001; req_addr[0] = 10'h102; req_data[0] = 32'hCAFE0002; req_be[0] = 4'hF;
    #2;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_load_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    #2;
    tests_run++;
    if (bank_we !== 4'b0100 || bank_wdata[2] !== 32'hCAFE0002) begin
      tests_failed++;
      $display("FAIL reset_slot2_full: we=%b wdata=%h want 0100/cafe0002", bank_we, bank_wdata[2]);
    end
    #1 rst_i = 1'b1;
    #1;
    tests_run++;
    if (bank_we !== 4'b0000 || starve !== 3'b000 || bank_wdata[2] !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: we=%b starve=%b wdata=%h want 0000/000/0", bank_we, starve, bank_wdata[2]);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_fixed_priority();
    tick();
    bank_ready = '1;
    req_valid = 3'b011;
    req_addr[0] = 10'h011; req_data[0] = 32'h11110000; req_be[0] = 4'hF;
    req_addr[1] = 10'h025; req_data[1] = 32'h22220001; req_be[1] = 4'h5;
    #2;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL prio_ready0: got %b want 001", req_ready);
    end
    tick();
    req_valid = 3'b010;
    #2;
    tests_run++;
    if (bank_we !== 4'b0010 || bank_src[1] !== 2'd0 || bank_waddr[1] !== 10'h011) begin
      tests_failed++;
      $display("FAIL prio_bank1_first: we=%b src=%0d addr=%h want 0010/0/011", bank_we, bank_src[1], bank_waddr[1]);
    end
    tests_run++;
    if (req_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL prio_ready1: got %b want 010", req_ready);
    end
    tick();
    req_valid = '0;
    #2;
    tests_run++;
    if (bank_we !== 4'b0010 || bank_src[1] !== 2'd1 || bank_wdata[1] !== 32'h22220001 || bank_wbe[1] !== 4'h5) begin
      tests_failed++;
      $display("FAIL prio_bank1_second: we=%b src=%0d data=%h be=%h want 0010/1/22220001/5",
               bank_we, bank_src[1], bank_wdata[1], bank_wbe[1]);
    end
    tick();
    #2;
    tests_run++;
    if (bank_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL prio_drained: got %b want 0000", bank_we);
    end
  endtask

  task automatic test_parallel_banks();
    tick();
    bank_ready = '1;
    req_valid = 3'b111;
    req_addr[0] = 10'h040; req_data[0] = 32'hA0A0A0A0;
    req_addr[1] = 10'h052; req_data[1] = 32'hB1B1B1B1;
    req_addr[2] = 10'h063; req_data[2] = 32'hC2C2C2C2;
    #2;
    tests_run++;
    if (req_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL par_ready: got %b want 111", req_ready);
    end
    tick();
    req_valid = '0;
    #2;
    tests_run++;
    if (bank_we !== 4'b1101 || bank_src[2] !== 2'd1 || bank_src[3] !== 2'd2 || bank_wdata[3] !== 32'hC2C2C2C2) begin
      tests_failed++;
      $display("FAIL par_banks: we=%b src2=%0d src3=%0d data3=%h want 1101/1/2/c2c2c2c2",
               bank_we, bank_src[2], bank_src[3], bank_wdata[3]);
    end
    tick();
    #2;
    tests_run++;
    if (bank_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL par_drained: got %b want 0000", bank_we);
    end
  endtask

  task automatic test_starvation();
    int         won_at = -1;
    logic [2:0] rdy;
    logic [9:0] starve_hist = '0;
    tick();
    bank_ready = '1;
    req_valid = 3'b101;
    req_addr[0] = 10'h200; req_data[0] = 32'h000000A0; req_be[0] = 4'hF;
    req_addr[2] = 10'h080; req_data[2] = 32'h000000C2; req_be[2] = 4'h9;
    for (int i = 0; i < 10; i++) begin
      #2;
      rdy = req_ready;
      starve_hist[i] = starve[2];
      if (rdy[2] && won_at < 0) won_at = i;
      tick();
      if (rdy[0]) begin
        req_addr[0] = req_addr[0] + 10'd4;
        req_data[0] = req_data[0] + 32'd1;
      end
      if (rdy[2]) req_valid[2] = 1'b0;
    end
`ifdef SPATZ_VRF_WR_ARB_STARVE_EN
    tests_run++;
    if (won_at !== 4) begin
      tests_failed++;
      $display("FAIL starve_win_cycle: got %0d want 4", won_at);
    end
    tests_run++;
    if (starve_hist !== 10'b00_0001_0000) begin
      tests_failed++;
      $display("FAIL starve_flag_hist: got %b want 0000010000", starve_hist);
    end
`else
    tests_run++;
    if (won_at !== -1) begin
      tests_failed++;
      $display("FAIL fixed_no_win: req2 won at cycle %0d, want never", won_at);
    end
    tests_run++;
    if (starve_hist !== 10'b0) begin
      tests_failed++;
      $display("FAIL fixed_starve_flag: got %b want 0", starve_hist);
    end
`endif
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    tick();
    bank_ready = 4'b0111;
    req_valid = 3'b001;
    req_addr[0] = 10'h093; req_data[0] = 32'hDEAD0003; req_be[0] = 4'hF;
    #2;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL bp_first_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = 3'b010;
    req_addr[1] = 10'h0A7; req_data[1] = 32'hBEEF0007; req_be[1] = 4'h3;
    for (int k = 0; k < 3; k++) begin
      #2;
      tests_run++;
      if (bank_we[3] !== 1'b1 || bank_wdata[3] !== 32'hDEAD0003 || req_ready !== 3'b000) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: we3=%b data3=%h ready=%b want 1/dead0003/000", k, bank_we[3], bank_wdata[3], req_ready);
      end
      tick();
    end
    bank_ready = 4'b1111;
    #2;
    tests_run++;
    if (req_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b want 010", req_ready);
    end
    tick();
    req_valid = '0;
    #2;
    tests_run++;
    if (bank_we[3] !== 1'b1 || bank_wdata[3] !== 32'hBEEF0007 || bank_src[3] !== 2'd1 || bank_wbe[3] !== 4'h3) begin
      tests_failed++;
      $display("FAIL bp_back_to_back: we3=%b data3=%h src3=%0d be3=%h want 1/beef0007/1/3",
               bank_we[3], bank_wdata[3], bank_src[3], bank_wbe[3]);
    end
    tick();
    #2;
    tests_run++;
    if (bank_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_drained: got %b want 0000", bank_we);
    end
  endtask

  task automatic test_random();
    logic [2:0] rdy;
    exp_t       e;
    exp_t       got;
    bit         draining;
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 2010; cyc++) begin
      draining = (cyc >= 2000);
      for (int r = 0; r < 3; r++) begin
        if (!req_valid[r] && !draining && ($urandom_range(0, 1) == 1)) begin
          req_valid[r] = 1'b1;
          req_addr[r]  = vreg_addr_t'($urandom);
          req_data[r]  = $urandom;
          req_be[r]    = vreg_be_t'($urandom);
        end
      end
      bank_ready = draining ? 4'b1111 : 4'($urandom);
      #2;
      rdy = req_ready;
      for (int b = 0; b < 4; b++) begin
        tests_run++;
        if (bank_we[b] !== (exp_q[b].size() != 0)) begin
          tests_failed++;
          $display("FAIL rnd_we_b%0d cyc %0d: got %b want %b", b, cyc, bank_we[b], exp_q[b].size() != 0);
        end
        if (bank_we[b] === 1'b1 && bank_ready[b]) begin
          got = '{addr: bank_waddr[b], data: bank_wdata[b], be: bank_wbe[b], src: bank_src[b]};
          tests_run++;
          if (exp_q[b].size() == 0) begin
            tests_failed++;
            $display("FAIL rnd_extra_b%0d cyc %0d: got %h want nothing", b, cyc, got);
          end else begin
            e = exp_q[b].pop_front();
            if (got !== e) begin
              tests_failed++;
              $display("FAIL rnd_data_b%0d cyc %0d: got %h want %h", b, cyc, got, e);
            end
          end
        end
      end
      for (int r = 0; r < 3; r++) begin
        if (rdy[r] === 1'b1) begin
          if (!req_valid[r]) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rnd_ready_no_valid r%0d cyc %0d: got 1 want 0", r, cyc);
          end else begin
            e = '{addr: req_addr[r], data: req_data[r], be: req_be[r], src: 2'(r)};
            exp_q[int'(req_addr[r][1:0])].push_back(e);
          end
        end
      end
      tick();
      for (int r = 0; r < 3; r++) if (rdy[r] === 1'b1) req_valid[r] = 1'b0;
    end
    tests_run++;
    if (req_valid !== 3'b000 || exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_leftover: valid=%b queued=%0d want 000/0", req_valid,
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end
  endtask

  initial begin
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    req_be     = '0;
    bank_ready = '0;
    test_reset();
    test_fixed_priority();
    test_parallel_banks();
    test_starvation();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
